// File: rtl/clock_pkg.sv
// Shared clock-domain types and limits for the time/alarm editor, timekeeper and alarm comparator.
package clock_pkg;
  localparam int MIN_W    = 7;
  localparam int HOUR_W   = 6;
  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;

  typedef enum logic [2:0] {
    IDLE,
    TIME_HOURS,
    TIME_MINUTES,
    ALARM_HOURS,
    ALARM_MINUTES
  } setting_state_t;

  // Compare before adding so an out-of-range value wraps straight to 0.
  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] v);
    return (v >= MIN_W'(MAX_MIN)) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] v);
    return (v >= HOUR_W'(MAX_HOUR)) ? '0 : v + 1'b1;
  endfunction
endpackage

// File: rtl/setting_controller_btn_edge.sv
// One-bit rising-edge detector; the edge is visible in the same cycle the high level arrives.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= btn_i;
  end

  assign rise_o = btn_i & ~prev_q;
endmodule

// File: rtl/setting_controller.sv
// Button-driven time/alarm editor with registered outputs and a one-cycle time_load commit.
// Optional inactivity timeout is enabled with `define SETTING_TIMEOUT_EN.
module setting_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_select,
  input  logic              btn_inc,
  input  logic              tick_1hz,
  input  logic [MIN_W-1:0]  minutes,
  input  logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes_settings,
  output logic [HOUR_W-1:0] hours_settings,
  output logic              time_settings_signal,
  output logic              alarm_settings_signal,
  output logic              edit_hours,
  output logic              time_load,
  output logic [MIN_W-1:0]  alarm_minutes,
  output logic [HOUR_W-1:0] alarm_hours
);
  logic mode_e, sel_e, inc_e;

  btn_edge u_mode (.clk(clk), .rst(rst), .btn_i(btn_mode),   .rise_o(mode_e));
  btn_edge u_sel  (.clk(clk), .rst(rst), .btn_i(btn_select), .rise_o(sel_e));
  btn_edge u_inc  (.clk(clk), .rst(rst), .btn_i(btn_inc),    .rise_o(inc_e));

  setting_state_t    state_q, state_d;
  logic [MIN_W-1:0]  min_q, min_d, am_q, am_d;
  logic [HOUR_W-1:0] hr_q, hr_d, ah_q, ah_d;
  logic              tl_d;

`ifdef SETTING_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             any_edge, timeout;

  assign any_edge = mode_e | sel_e | inc_e;
  // A button edge in the timeout cycle wins: the edit stays alive.
  assign timeout  = tick_1hz && (state_q != IDLE) && !any_edge &&
                    (idle_cnt_q >= CNT_W'(TIMEOUT_S - 1));
`else
  logic unused_tick;
  localparam int unused_timeout = TIMEOUT_S;
  assign unused_tick = tick_1hz;
`endif

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    hr_d    = hr_q;
    am_d    = am_q;
    ah_d    = ah_q;
    tl_d    = 1'b0;
    case (state_q)
      IDLE: if (mode_e) begin
        state_d = TIME_HOURS;
        min_d   = minutes;
        hr_d    = hours;
      end
      TIME_HOURS, TIME_MINUTES: begin
        if (mode_e) begin
          state_d = ALARM_HOURS;
          min_d   = am_q;
          hr_d    = ah_q;
        end else if (sel_e) begin
          if (state_q == TIME_HOURS) state_d = TIME_MINUTES;
          else begin
            state_d = IDLE;
            tl_d    = 1'b1;
          end
        end else if (inc_e) begin
          if (state_q == TIME_HOURS) hr_d  = inc_hour(hr_q);
          else                       min_d = inc_min(min_q);
        end
      end
      ALARM_HOURS, ALARM_MINUTES: begin
        if (mode_e) state_d = IDLE;
        else if (sel_e) begin
          if (state_q == ALARM_HOURS) state_d = ALARM_MINUTES;
          else begin
            state_d = IDLE;
            am_d    = min_q;
            ah_d    = hr_q;
          end
        end else if (inc_e) begin
          if (state_q == ALARM_HOURS) hr_d  = inc_hour(hr_q);
          else                        min_d = inc_min(min_q);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef SETTING_TIMEOUT_EN
    if (timeout) state_d = IDLE;
    idle_cnt_d = idle_cnt_q;
    if (any_edge || (state_d != state_q))   idle_cnt_d = '0;
    else if (tick_1hz && state_q != IDLE)   idle_cnt_d = idle_cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      min_q                 <= '0;
      hr_q                  <= '0;
      am_q                  <= '0;
      ah_q                  <= '0;
      time_load             <= 1'b0;
      time_settings_signal  <= 1'b0;
      alarm_settings_signal <= 1'b0;
      edit_hours            <= 1'b0;
`ifdef SETTING_TIMEOUT_EN
      idle_cnt_q            <= '0;
`endif
    end else begin
      state_q               <= state_d;
      min_q                 <= min_d;
      hr_q                  <= hr_d;
      am_q                  <= am_d;
      ah_q                  <= ah_d;
      time_load             <= tl_d;
      time_settings_signal  <= (state_d == TIME_HOURS)  || (state_d == TIME_MINUTES);
      alarm_settings_signal <= (state_d == ALARM_HOURS) || (state_d == ALARM_MINUTES);
      edit_hours            <= (state_d == TIME_HOURS)  || (state_d == ALARM_HOURS);
`ifdef SETTING_TIMEOUT_EN
      idle_cnt_q            <= idle_cnt_d;
`endif
    end
  end

  assign minutes_settings = min_q;
  assign hours_settings   = hr_q;
  assign alarm_minutes    = am_q;
  assign alarm_hours      = ah_q;
endmodule

// File: tb/tb_setting_controller.sv
// Self-checking bench: directed scenarios plus random button traffic against a behavioural editor model.
module tb_setting_controller;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0, btn_select = 1'b0, btn_inc = 1'b0, tick_1hz = 1'b0;
  logic [6:0] minutes = '0;
  logic [5:0] hours = '0;
  logic [6:0] minutes_settings, alarm_minutes;
  logic [5:0] hours_settings, alarm_hours;
  logic       time_settings_signal, alarm_settings_signal, edit_hours, time_load;

  always #5 clk = ~clk;

  setting_controller #(.TIMEOUT_S(TO)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_select(btn_select), .btn_inc(btn_inc),
    .tick_1hz(tick_1hz), .minutes(minutes), .hours(hours),
    .minutes_settings(minutes_settings), .hours_settings(hours_settings),
    .time_settings_signal(time_settings_signal), .alarm_settings_signal(alarm_settings_signal),
    .edit_hours(edit_hours), .time_load(time_load),
    .alarm_minutes(alarm_minutes), .alarm_hours(alarm_hours)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: what is being edited (0 none, 1 clock, 2 alarm) and which field.
  int edit_what = 0;
  bit on_hours  = 0;
  int sm = 0, sh = 0, am = 0, ah = 0, secs = 0;
  bit tl = 0, pm = 0, ps = 0, pi = 0;
  int cur_min = 0, cur_hr = 0;

  task automatic model_step(input bit r, m, s, i, t, input int mi, hr);
    bit me, se, ie, prev_hrs;
    int prev_what;
    if (r) begin
      edit_what = 0; on_hours = 0; sm = 0; sh = 0; am = 0; ah = 0;
      tl = 0; pm = 0; ps = 0; pi = 0; secs = 0;
      return;
    end
    me = m && !pm; se = s && !ps; ie = i && !pi;
    pm = m; ps = s; pi = i;
    tl = 0;
    prev_what = edit_what; prev_hrs = on_hours;
    if (me) begin
      if (edit_what == 0)      begin edit_what = 1; on_hours = 1; sm = mi; sh = hr; end
      else if (edit_what == 1) begin edit_what = 2; on_hours = 1; sm = am; sh = ah; end
      else edit_what = 0;
    end else if (se && edit_what != 0) begin
      if (on_hours) on_hours = 0;
      else begin
        if (edit_what == 1) tl = 1;
        else begin am = sm; ah = sh; end
        edit_what = 0;
      end
    end else if (ie && edit_what != 0) begin
      if (on_hours) sh = (sh > 22) ? 0 : sh + 1;
      else          sm = (sm > 58) ? 0 : sm + 1;
    end
`ifdef SETTING_TIMEOUT_EN
    if (me || se || ie || edit_what != prev_what || on_hours != prev_hrs) secs = 0;
    else if (t && edit_what != 0) begin
      secs++;
      if (secs >= TO) begin edit_what = 0; secs = 0; end
    end
`endif
  endtask

  task automatic compare_all();
    chk("min_set",   minutes_settings, sm);
    chk("hour_set",  hours_settings, sh);
    chk("time_sig",  time_settings_signal, edit_what == 1);
    chk("alarm_sig", alarm_settings_signal, edit_what == 2);
    chk("edit_hrs",  edit_hours, edit_what != 0 && on_hours);
    chk("time_load", time_load, tl);
    chk("alarm_min", alarm_minutes, am);
    chk("alarm_hr",  alarm_hours, ah);
  endtask

  task automatic cyc(input bit r, m, s, i, t);
    @(negedge clk);
    rst = r; btn_mode = m; btn_select = s; btn_inc = i; tick_1hz = t;
    minutes = 7'(cur_min); hours = 6'(cur_hr);
    model_step(r, m, s, i, t, cur_min, cur_hr);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic press(input bit m, s, i, input bit t = 1'b0);
    cyc(0, m, s, i, t);
    cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_alarm", {alarm_hours, alarm_minutes}, 0);
    chk("rst_flags", {time_settings_signal, alarm_settings_signal, edit_hours, time_load}, 0);

    // Enter clock edit with 12:34 on the timekeeper.
    cur_min = 34; cur_hr = 12;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("enter_tsig", time_settings_signal, 1);
    chk("enter_eh", edit_hours, 1);
    chk("enter_val", {hours_settings, minutes_settings}, {6'd12, 7'd34});
    cyc(0, 0, 0, 0, 0);
    repeat (11) press(0, 0, 1);
    chk("hr_23", hours_settings, 23);
    press(0, 0, 1);
    chk("hr_wrap", hours_settings, 0);
    press(0, 1, 0);
    repeat (25) press(0, 0, 1);
    chk("min_59", minutes_settings, 59);
    press(0, 0, 1);
    chk("min_wrap", minutes_settings, 0);
    chk("no_carry", hours_settings, 0);
    cyc(0, 0, 1, 0, 0);
    chk("commit_tl", time_load, 1);
    chk("commit_val", {hours_settings, minutes_settings}, 0);
    chk("commit_idle", time_settings_signal, 0);
    cyc(0, 0, 0, 0, 0);
    chk("tl_one_cyc", time_load, 0);

    // Alarm edit to 07:30, then an abandoned edit must leave it alone.
    press(1, 0, 0);
    press(1, 0, 0);
    chk("alarm_enter", alarm_settings_signal, 1);
    chk("alarm_load", {hours_settings, minutes_settings}, 0);
    repeat (7) press(0, 0, 1);
    press(0, 1, 0);
    repeat (30) press(0, 0, 1);
    press(0, 1, 0);
    chk("alarm_stored", {alarm_hours, alarm_minutes}, {6'd7, 7'd30});
    press(1, 0, 0);
    press(0, 0, 1);
    press(1, 0, 0);
    chk("alarm_kept", {alarm_hours, alarm_minutes}, {6'd7, 7'd30});

    // Simultaneous mode+inc from TIME_HOURS, then a long inc hold.
    press(1, 0, 0);
    press(1, 0, 0);
    chk("th_again", time_settings_signal, 1);
    press(1, 0, 1);
    chk("prio_alarm", alarm_settings_signal, 1);
    chk("prio_noinc", hours_settings, 7);
    repeat (100) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("hold_once", hours_settings, 8);

    // Reset in the middle of a minutes edit.
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    chk("midrst", {minutes_settings, hours_settings, alarm_minutes, alarm_hours,
                   time_settings_signal, alarm_settings_signal, edit_hours, time_load}, 0);
    cyc(0, 0, 0, 0, 0);
    chk("midrst_tl", time_load, 0);

`ifdef SETTING_TIMEOUT_EN
    press(1, 0, 0);
    repeat (3) begin cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0); end
    chk("to_idle", time_settings_signal, 0);
    chk("to_no_tl", time_load, 0);
    press(1, 0, 0);
    repeat (2) begin cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0); end
    press(0, 0, 1, 1'b1);
    chk("to_edge_wins", time_settings_signal, 1);
    press(1, 0, 0);
    press(1, 0, 0);
`endif

    // Random traffic, including out-of-range time inputs and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        cur_min = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 59);
        cur_hr  = ($urandom_range(0, 7) == 0) ? $urandom_range(24, 63)  : $urandom_range(0, 23);
      end
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
